// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stage indices, stall/flush patterns and FSM encoding for the pipeline sequencer.
// No logic of its own: latency and backpressure are defined by the users.
package pipe_ctrl_pkg;

    localparam int RADDR_WIDTH    = 5;
    localparam int ADDR_WIDTH     = 32;
    localparam int N_STAGE        = 5;
    localparam int MC_TIMEOUT_DEF = 64;

    localparam int STALL_PC      = 0;
    localparam int STALL_IF_ID   = 1;
    localparam int STALL_ID_EXE  = 2;
    localparam int STALL_EXE_MEM = 3;
    localparam int STALL_MEM_WB  = 4;

    typedef logic [N_STAGE-1:0] stage_vec_t;

    localparam stage_vec_t BIT_PC      = stage_vec_t'(1) << STALL_PC;
    localparam stage_vec_t BIT_IF_ID   = stage_vec_t'(1) << STALL_IF_ID;
    localparam stage_vec_t BIT_ID_EXE  = stage_vec_t'(1) << STALL_ID_EXE;
    localparam stage_vec_t BIT_EXE_MEM = stage_vec_t'(1) << STALL_EXE_MEM;
    localparam stage_vec_t BIT_MEM_WB  = stage_vec_t'(1) << STALL_MEM_WB;

    // Each hazard freezes everything upstream of a point and bubbles the stage just below it.
    localparam stage_vec_t STALL_MEM_WAIT = BIT_PC | BIT_IF_ID | BIT_ID_EXE | BIT_EXE_MEM;
    localparam stage_vec_t FLUSH_MEM_WAIT = BIT_MEM_WB;
    localparam stage_vec_t STALL_MC       = BIT_PC | BIT_IF_ID | BIT_ID_EXE;
    localparam stage_vec_t FLUSH_MC       = BIT_EXE_MEM;
    localparam stage_vec_t FLUSH_BRANCH   = BIT_IF_ID | BIT_ID_EXE;
    localparam stage_vec_t STALL_LOAD_USE = BIT_PC | BIT_IF_ID;
    localparam stage_vec_t FLUSH_LOAD_USE = BIT_ID_EXE;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_EXE_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard compare between the EXE load destination and the ID sources; x0 never hazards.
// Purely combinational, zero latency, no backpressure.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
    input  logic                   id_reg1_re_i,
    input  logic                   id_reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    input  logic                   exe_reg_we_i,
    input  logic                   exe_is_load_i,
    output logic                   hazard_o
);

    logic src1_hit;
    logic src2_hit;

    always_comb begin
        src1_hit = id_reg1_re_i & (id_reg1_raddr_i == exe_reg_waddr_i);
        src2_hit = id_reg2_re_i & (id_reg2_raddr_i == exe_reg_waddr_i);
        hazard_o = exe_is_load_i & exe_reg_we_i & (exe_reg_waddr_i != '0) & (src1_hit | src2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: mem wait > multi-cycle EXE > branch redirect > load-use, Mealy stall/flush per stage.
// Zero-latency control outputs; stalls upstream stages while memory or the multi-cycle unit is busy.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
    input  logic                   id_reg1_re_i,
    input  logic                   id_reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    input  logic                   exe_reg_we_i,
    input  logic                   exe_is_load_i,
    input  logic                   exe_mc_req_i,
    input  logic                   mc_done_i,
    output logic                   mc_start_o,
    input  logic                   exe_branch_i,
    input  logic [ADDR_WIDTH-1:0]  exe_branch_target_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ready_i,
    output logic [N_STAGE-1:0]     stall_o,
    output logic [N_STAGE-1:0]     flush_o,
    output logic                   redirect_o,
    output logic [ADDR_WIDTH-1:0]  redirect_pc_o,
    output logic                   mc_err_o,
    output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

    localparam int              TO_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            done_seen;
    logic            mem_wait;
    logic            load_use;
    logic            to_hit;
    logic            mc_exit;

    load_use_detect u_load_use_detect (
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .id_reg1_re_i    (id_reg1_re_i),
        .id_reg2_re_i    (id_reg2_re_i),
        .exe_reg_waddr_i (exe_reg_waddr_i),
        .exe_reg_we_i    (exe_reg_we_i),
        .exe_is_load_i   (exe_is_load_i),
        .hazard_o        (load_use)
    );

    always_comb begin
        mem_wait = mem_req_i & ~mem_ready_i;
        to_hit   = (to_cnt == TO_LAST);
        // A timeout releases exactly like a done; neither can release during a mem wait.
        mc_exit  = (state == ST_EXE_WAIT) & ~mem_wait & (mc_done_i | done_seen | to_hit);
    end

    always_comb begin
        stall_o       = '0;
        flush_o       = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        mc_start_o    = 1'b0;
        if (rst_i) begin
            stall_o = '0;
        end else if (mem_wait) begin
            stall_o = STALL_MEM_WAIT;
            flush_o = FLUSH_MEM_WAIT;
        end else if (state == ST_EXE_WAIT) begin
            if (!mc_exit) begin
                stall_o = STALL_MC;
                flush_o = FLUSH_MC;
            end
        end else if (exe_mc_req_i) begin
            mc_start_o = 1'b1;
            stall_o    = STALL_MC;
            flush_o    = FLUSH_MC;
        end else if (exe_branch_i) begin
            redirect_o    = 1'b1;
            redirect_pc_o = exe_branch_target_i;
            flush_o       = FLUSH_BRANCH;
        end else if (load_use) begin
            stall_o = STALL_LOAD_USE;
            flush_o = FLUSH_LOAD_USE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_RUN;
            to_cnt      <= '0;
            done_seen   <= 1'b0;
            mc_err_o    <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if ((stall_o != '0) && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
            end
            case (state)
                ST_RUN: begin
                    if (!mem_wait && exe_mc_req_i) begin
                        state     <= ST_EXE_WAIT;
                        to_cnt    <= '0;
                        done_seen <= 1'b0;
                    end
                end
                ST_EXE_WAIT: begin
                    if (mc_exit) begin
                        state     <= ST_RUN;
                        to_cnt    <= '0;
                        done_seen <= 1'b0;
                        if (to_hit && !mc_done_i && !done_seen) begin
                            mc_err_o <= 1'b1;
                        end
                    end else begin
                        if (!to_hit) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                        if (mc_done_i) begin
                            done_seen <= 1'b1;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32 core. It detects load-use hazards and sequences multi-cycle EXE operations such as the divider. It also handles data-memory wait states and EXE branch redirects, driving per-stage stall/flush vectors into pc_reg, if_id, id_exe, exe_mem and mem_wb. The forwarding unit stays as is; this block covers only what forwarding cannot.

Parameters:
MC_TIMEOUT, 64, max EXE_WAIT cycles before forced release and sticky error
CNT_WIDTH, 32, width of stall-cycle performance counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
id_reg1_raddr_i  in  `RADDR_WIDTH  ID source 1 address
id_reg2_raddr_i  in  `RADDR_WIDTH  ID source 2 address
id_reg1_re_i  in  1  source 1 read enable
id_reg2_re_i  in  1  source 2 read enable
exe_reg_waddr_i  in  `RADDR_WIDTH  EXE destination
exe_reg_we_i  in  1  EXE writes register
exe_is_load_i  in  1  EXE instruction is a load
exe_mc_req_i  in  1  EXE instruction needs multi-cycle unit
mc_done_i  in  1  multi-cycle unit result valid (1-cycle pulse)
mc_start_o  out  1  start pulse to multi-cycle unit
exe_branch_i  in  1  EXE resolved taken branch/jump
exe_branch_target_i  in  `ADDR_WIDTH  redirect target
mem_req_i  in  1  MEM stage accessing data memory
mem_ready_i  in  1  data memory ready
stall_o  out  5  hold stage regs: [0]pc [1]if_id [2]id_exe [3]exe_mem [4]mem_wb
flush_o  out  5  load bubble into same-index stage reg
redirect_o  out  1  load pc with redirect_pc_o
redirect_pc_o  out  `ADDR_WIDTH  new pc
mc_err_o  out  1  sticky: timeout occurred
stall_cnt_o  out  CNT_WIDTH  cycles with any stall_o bit set, saturating

Behaviour:
- States: RUN, EXE_WAIT. Registered state; all stall/flush/redirect outputs combinational (Mealy) from state and inputs.
- Reset (rst_i=1 at clk edge): state=RUN, timeout counter=0, done_seen=0, mc_err_o=0, stall_cnt_o=0. While rst_i=1, stall_o, flush_o, redirect_o, mc_start_o and redirect_pc_o are forced to 0.
- Priority, highest first: mem wait > multi-cycle > branch > load-use. Only the highest active condition drives outputs.
- Mem wait: mem_req_i & ~mem_ready_i. Outputs stall_o=5'b01111, flush_o=5'b10000. Valid in either state; the state is held. Release occurs in the same cycle mem_ready_i rises.
- Multi-cycle, RUN: exe_mc_req_i=1 with no mem wait gives mc_start_o=1 for one cycle, next state EXE_WAIT, stall_o=5'b00111, flush_o=5'b01000. mc_done_i is ignored in RUN.
- EXE_WAIT: stall_o=5'b00111, flush_o=5'b01000; mc_start_o=0; the timeout counter increments each cycle.
  - A mc_done_i pulse arriving during a mem wait sets done_seen.
  - Exit when (mc_done_i | done_seen) and there is no mem wait. In the exit cycle stall_o=0 and flush_o=0, so the result enters exe_mem. Next state RUN; done_seen and the counter clear.
  - If the counter reaches MC_TIMEOUT-1 without done: set mc_err_o, exit as if done.
- Branch: exe_branch_i in RUN with no higher condition gives redirect_o=1, redirect_pc_o=exe_branch_target_i, flush_o=5'b00110, stall_o=0. Single cycle. A concurrent load-use is suppressed because the ID instruction is flushed.
- Load-use: exe_is_load_i & exe_reg_we_i & exe_reg_waddr_i!=0 & ((id_reg1_re_i & id_reg1_raddr_i==exe_reg_waddr_i) | (id_reg2_re_i & id_reg2_raddr_i==exe_reg_waddr_i)). Outputs stall_o=5'b00011, flush_o=5'b00100. Exactly one bubble; the next cycle resolves via MEM forwarding. x0 never hazards.
- stall_cnt_o increments on any cycle with stall_o!=0 and saturates at all-ones.
- Reset mid-EXE_WAIT: returns to RUN with no mc_start_o. The multi-cycle unit is reset by the same rst_i.

Decomposition:
- defines.v: stall/flush bit indices (STALL_PC..STALL_MEM_WB), state encodings, MC_TIMEOUT default.
- One natural combinational sub-module, load_use_detect (hazard compare only). The FSM and counters stay in pipe_ctrl.

Test Plan:
- Load-use: exe load x5, ID reads x5 on rs2 -> one cycle stall_o=00011, flush_o=00100; next cycle all 0. Same case with waddr=0 -> no stall.
- Divider: exe_mc_req_i=1, mc_done_i after 10 cycles -> mc_start_o once; stall_o=00111 for 10 cycles; 0 on the done cycle; stall_cnt_o=10.
- Timeout: MC_TIMEOUT=8, no done -> release after 8 EXE_WAIT cycles, mc_err_o=1 and stays 1 until rst_i.
- Mem wait overlapping EXE_WAIT: mc_done_i pulses while mem_ready_i=0 -> stall_o=01111, flush_o=10000; release the cycle mem_ready_i=1; no extra wait.
- Branch with load-use simultaneously: target 0x0000_0100 -> redirect_o=1, redirect_pc_o=0x100, flush_o=00110, stall_o=0.
- Sync reset asserted in EXE_WAIT -> next cycle state RUN, all outputs 0, stall_cnt_o=0.
